// File: rtl/dds_uart_pkg.sv
// Shared types and defaults for the UART command path (frame parser and
// register mapper agree on payload length, header bytes and byte timeout).
package dds_uart_pkg;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        HDR1    = 2'd1,
        PAYLOAD = 2'd2,
        CHECK   = 2'd3
    } parser_state_e;

    localparam logic [7:0] HDR0_DEF          = 8'h55;
    localparam logic [7:0] HDR1_DEF          = 8'hAA;
    localparam int         PAYLOAD_BYTES_DEF = 12;
    localparam int         TIMEOUT_CYC_DEF   = 50000;

endpackage

// File: rtl/byte_gap_timer.sv
// Idle-gap watchdog: counts clocks since the last byte strobe while enabled
// and pulses expire_o when the gap reaches _TIMEOUT_CYC clocks.
module byte_gap_timer #(
    parameter int _TIMEOUT_CYC = 50000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic enable_i,
    input  logic clr_i,
    output logic expire_o
);

    localparam int CW = (_TIMEOUT_CYC > 2) ? $clog2(_TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(_TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // A strobe landing in the terminal cycle suppresses the expiry.
    assign expire_o = enable_i && !clr_i && (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (!enable_i || clr_i || expire_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_frame_parser.sv
// Turns the UART byte stream into checksum-verified payload frames and
// publishes each good frame as a stable register bank with a pack_done pulse.
module uart_frame_parser
    import dds_uart_pkg::*;
#(
    parameter int         _PAYLOAD_BYTES = PAYLOAD_BYTES_DEF,
    parameter logic [7:0] _HDR0          = HDR0_DEF,
    parameter logic [7:0] _HDR1          = HDR1_DEF,
    parameter int         _TIMEOUT_CYC   = TIMEOUT_CYC_DEF
) (
    input  logic                        sys_clk,
    input  logic                        sys_rst,
    input  logic [7:0]                  uart_data,
    input  logic                        uart_done,
    output logic [8*_PAYLOAD_BYTES-1:0] rev_data,
    output logic                        pack_done,
    output logic [7:0]                  pack_num,
    output logic                        frame_err,
    output logic [7:0]                  err_cnt,
    output logic                        busy
);

    localparam int IDX_W = (_PAYLOAD_BYTES > 1) ? $clog2(_PAYLOAD_BYTES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(_PAYLOAD_BYTES - 1);

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    parser_state_e                 state_q,     state_d;
    logic [IDX_W-1:0]              idx_q,       idx_d;
    logic [7:0]                    sum_q,       sum_d;
    logic [8*_PAYLOAD_BYTES-1:0]   staging_q,   staging_d;
    logic [8*_PAYLOAD_BYTES-1:0]   rev_q,       rev_d;
    logic [7:0]                    pack_num_q,  pack_num_d;
    logic [7:0]                    err_cnt_q,   err_cnt_d;
    logic                          pack_done_q, pack_done_d;
    logic                          frame_err_q, frame_err_d;
    logic                          expire;

    assign busy = (state_q != HUNT);

    byte_gap_timer #(
        ._TIMEOUT_CYC(_TIMEOUT_CYC)
    ) u_gap_timer (
        .clk_i    (sys_clk),
        .rst_i    (sys_rst),
        .enable_i (busy),
        .clr_i    (uart_done),
        .expire_o (expire)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        sum_d       = sum_q;
        staging_d   = staging_q;
        rev_d       = rev_q;
        pack_num_d  = pack_num_q;
        err_cnt_d   = err_cnt_q;
        pack_done_d = 1'b0;
        frame_err_d = 1'b0;

        // expire is never asserted together with uart_done.
        if (expire) begin
            state_d     = HUNT;
            frame_err_d = 1'b1;
            err_cnt_d   = sat_inc8(err_cnt_q);
        end else if (uart_done) begin
            unique case (state_q)
                HUNT: begin
                    if (uart_data == _HDR0) state_d = HDR1;
                end
                HDR1: begin
                    if (uart_data == _HDR1) begin
                        state_d = PAYLOAD;
                        idx_d   = '0;
                        sum_d   = 8'd0;
                    end else if (uart_data != _HDR0) begin
                        state_d = HUNT;
                    end
                end
                PAYLOAD: begin
                    staging_d[8*idx_q +: 8] = uart_data;
                    sum_d = sum_q + uart_data;
                    if (idx_q == IDX_LAST) begin
                        state_d = CHECK;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
                CHECK: begin
                    if (uart_data == sum_q) begin
                        rev_d       = staging_q;
                        pack_done_d = 1'b1;
                        pack_num_d  = pack_num_q + 8'd1;
                    end else begin
                        frame_err_d = 1'b1;
                        err_cnt_d   = sat_inc8(err_cnt_q);
                    end
                    state_d = HUNT;
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q     <= HUNT;
            idx_q       <= '0;
            sum_q       <= 8'd0;
            staging_q   <= '0;
            rev_q       <= '0;
            pack_num_q  <= 8'd0;
            err_cnt_q   <= 8'd0;
            pack_done_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            sum_q       <= sum_d;
            staging_q   <= staging_d;
            rev_q       <= rev_d;
            pack_num_q  <= pack_num_d;
            err_cnt_q   <= err_cnt_d;
            pack_done_q <= pack_done_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign rev_data  = rev_q;
    assign pack_done = pack_done_q;
    assign pack_num  = pack_num_q;
    assign frame_err = frame_err_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Bench for uart_frame_parser: table of frame vectors plus hand-written
// timeout/reset/wrap sequences, checked through an expected-event queue.
module tb_uart_frame_parser;

    localparam int PB = 12;
    localparam int TO = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic [7:0]        uart_data;
    logic              uart_done;
    logic [8*PB-1:0]   rev_data;
    logic              pack_done;
    logic [7:0]        pack_num;
    logic              frame_err;
    logic [7:0]        err_cnt;
    logic              busy;

    always #5 clk = ~clk;

    uart_frame_parser #(
        ._PAYLOAD_BYTES(PB),
        ._HDR0(8'h55),
        ._HDR1(8'hAA),
        ._TIMEOUT_CYC(TO)
    ) dut (
        .sys_clk   (clk),
        .sys_rst   (rst),
        .uart_data (uart_data),
        .uart_done (uart_done),
        .rev_data  (rev_data),
        .pack_done (pack_done),
        .pack_num  (pack_num),
        .frame_err (frame_err),
        .err_cnt   (err_cnt),
        .busy      (busy)
    );

    // kind: 0 = no event, 1 = published frame, 2 = frame error
    typedef struct {
        int              kind;
        logic [8*PB-1:0] rev;
        logic [7:0]      pn;
        logic [7:0]      ec;
    } exp_t;

    typedef struct {
        logic [31:0] pre;
        int          pre_n;
        bit          hdr;
        logic [7:0]  seed;
        bit          corrupt;
        int          idle;
        int          kind;
    } vec_t;

    exp_t            sbq[$];
    exp_t            mon_e;
    vec_t            vt[8];
    logic [8*PB-1:0] m_rev;
    logic [7:0]      m_pn;
    logic [7:0]      m_ec;
    int              checks   = 0;
    int              failures = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0 && (pack_done === 1'b1 || frame_err === 1'b1)) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_event: pack_done=%b frame_err=%b, expected no event", pack_done, frame_err);
            end else begin
                mon_e = sbq.pop_front();
                check("ev_pack_done", 128'(pack_done), 128'(mon_e.kind == 1));
                check("ev_frame_err", 128'(frame_err), 128'(mon_e.kind == 2));
                check("ev_rev_data", 128'(rev_data), 128'(mon_e.rev));
                check("ev_pack_num", 128'(pack_num), 128'(mon_e.pn));
                check("ev_err_cnt", 128'(err_cnt), 128'(mon_e.ec));
            end
        end
    end

    function automatic vec_t mkv(input logic [31:0] pre, input int pre_n, input bit hdr,
                                 input logic [7:0] seed, input bit corrupt, input int idle,
                                 input int kind);
        vec_t v;
        v.pre = pre; v.pre_n = pre_n; v.hdr = hdr; v.seed = seed;
        v.corrupt = corrupt; v.idle = idle; v.kind = kind;
        return v;
    endfunction

    function automatic logic [8*PB-1:0] mk_pl(input logic [7:0] seed);
        logic [8*PB-1:0] pl;
        for (int k = 0; k < PB; k++) pl[8*k +: 8] = seed + 8'(k);
        return pl;
    endfunction

    task automatic send_byte(input logic [7:0] b, input int idle);
        repeat (idle) @(negedge clk);
        uart_data = b;
        uart_done = 1'b1;
        @(negedge clk);
        uart_done = 1'b0;
        uart_data = 8'h00;
    endtask

    task automatic expect_frame(input logic [8*PB-1:0] pl);
        m_rev = pl;
        m_pn  = m_pn + 8'd1;
        sbq.push_back('{1, m_rev, m_pn, m_ec});
    endtask

    task automatic expect_err();
        if (m_ec != 8'hFF) m_ec = m_ec + 8'd1;
        sbq.push_back('{2, m_rev, m_pn, m_ec});
    endtask

    task automatic send_body(input logic [8*PB-1:0] pl, input bit corrupt, input int idle);
        logic [7:0] s = 8'd0;
        for (int k = 0; k < PB; k++) begin
            send_byte(pl[8*k +: 8], idle);
            s = s + pl[8*k +: 8];
        end
        send_byte(corrupt ? s + 8'd1 : s, idle);
    endtask

    task automatic send_frame(input logic [7:0] seed, input bit corrupt, input int idle);
        if (corrupt) expect_err();
        else         expect_frame(mk_pl(seed));
        send_byte(8'h55, idle);
        send_byte(8'hAA, idle);
        send_body(mk_pl(seed), corrupt, idle);
    endtask

    task automatic wait_err(input string name);
        int k = 0;
        for (int i = 1; i <= TO + 8; i++) begin
            @(negedge clk);
            if (frame_err === 1'b1) begin
                k = i;
                break;
            end
        end
        check(name, 128'(k), 128'(TO));
    endtask

    task automatic reset_model();
        m_rev = '0;
        m_pn  = 8'd0;
        m_ec  = 8'd0;
        sbq.delete();
    endtask

    initial begin
        logic [8*PB-1:0] pl;
        rst       = 1'b1;
        uart_data = 8'h00;
        uart_done = 1'b0;
        reset_model();
        repeat (3) @(negedge clk);
        check("rst_rev_data", 128'(rev_data), 128'(0));
        check("rst_pack_num", 128'(pack_num), 128'(0));
        check("rst_err_cnt", 128'(err_cnt), 128'(0));
        check("rst_pulses", 128'({pack_done, frame_err}), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        rst = 1'b0;
        @(negedge clk);

        vt[0] = mkv(32'h0,        0, 1, 8'h01, 0, 9, 1);
        vt[1] = mkv(32'h0,        0, 1, 8'h01, 1, 9, 2);
        vt[2] = mkv(32'h005555AA, 4, 0, 8'h20, 0, 2, 1);
        vt[3] = mkv(32'h5512AA00, 3, 0, 8'h01, 0, 1, 0);
        vt[4] = mkv(32'h0,        0, 1, 8'h80, 0, 0, 1);
        vt[5] = mkv(32'h0,        0, 1, 8'hF8, 1, 1, 2);
        vt[6] = mkv(32'h55000000, 1, 1, 8'h30, 0, 2, 1);
        vt[7] = mkv(32'h0,        0, 1, 8'h50, 0, 0, 1);

        for (int v = 0; v < 8; v++) begin
            if (vt[v].kind == 1) expect_frame(mk_pl(vt[v].seed));
            if (vt[v].kind == 2) expect_err();
            for (int p = 0; p < vt[v].pre_n; p++) send_byte(vt[v].pre[31-8*p -: 8], vt[v].idle);
            if (vt[v].hdr) begin
                send_byte(8'h55, vt[v].idle);
                send_byte(8'hAA, vt[v].idle);
            end
            send_body(mk_pl(vt[v].seed), vt[v].corrupt, vt[v].idle);
            if (v == 0) begin
                check("first_byte0", 128'(rev_data[7:0]), 128'(8'h01));
                check("first_byte11", 128'(rev_data[95:88]), 128'(8'h0C));
            end
        end

        // Timeout inside PAYLOAD after five bytes.
        send_byte(8'h55, 1);
        send_byte(8'hAA, 1);
        pl = mk_pl(8'h40);
        for (int k = 0; k < 5; k++) send_byte(pl[8*k +: 8], 1);
        check("busy_in_payload", 128'(busy), 128'(1));
        expect_err();
        wait_err("timeout_payload_latency");
        check("busy_after_abort", 128'(busy), 128'(0));
        send_frame(8'h40, 0, 3);

        // Timeout with only the first header byte seen.
        send_byte(8'h55, 0);
        expect_err();
        wait_err("timeout_hdr1_latency");

        // Strobe arriving in the exact expiry cycle keeps the frame alive.
        pl = mk_pl(8'h90);
        expect_frame(pl);
        send_byte(8'h55, 0);
        send_byte(8'hAA, 0);
        begin
            logic [7:0] s = 8'd0;
            for (int k = 0; k < PB; k++) begin
                send_byte(pl[8*k +: 8], (k == 4) ? TO - 1 : 0);
                s = s + pl[8*k +: 8];
            end
            send_byte(s, 0);
        end

        // Reset in the middle of a payload.
        send_byte(8'h55, 0);
        send_byte(8'hAA, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        rst = 1'b1;
        #1;
        check("midrst_rev_data", 128'(rev_data), 128'(0));
        check("midrst_counts", 128'({pack_num, err_cnt}), 128'(0));
        check("midrst_pulses", 128'({pack_done, frame_err}), 128'(0));
        check("midrst_busy", 128'(busy), 128'(0));
        check("midrst_sb_empty", 128'(sbq.size()), 128'(0));
        reset_model();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_frame(8'h61, 0, 1);
        check("post_rst_pack_num", 128'(pack_num), 128'(1));

        // 256 good frames from a clean reset: pack_num wraps to 0.
        rst = 1'b1;
        reset_model();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 256; i++) send_frame(8'(i), 0, 0);
        check("pack_num_wrap", 128'(pack_num), 128'(0));

        // 300 bad frames: err_cnt saturates.
        for (int i = 0; i < 300; i++) send_frame(8'(i * 3), 1, 0);
        check("err_cnt_sat", 128'(err_cnt), 128'(8'hFF));

        repeat (4) @(negedge clk);
        check("scoreboard_drained", 128'(sbq.size()), 128'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
